// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_types_pkg
// Description : Shared CPU types: RAM status codes, memory arbiter FSM states
//               and the arbiter's last-grant marker.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_types_pkg;

  // RAM status as reported by the memory on its ramstate lines
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IACC = 2'd1,
    DACC = 2'd2
  } arb_state_t;

  // Which requester completed the most recent access
  typedef enum logic {
    INSTR = 1'b0,
    DATA  = 1'b1
  } grant_t;

  localparam int STAT_W = 32;

endpackage
`default_nettype wire

// File: rtl/memory_arbiter_stats.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter_stats
// Description : Free-running hit and stall counters for memory_arbiter.
//               Present only when MEM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter_stats
  import cpu_types_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              active,
  output logic [STAT_W-1:0] icount,
  output logic [STAT_W-1:0] dcount,
  output logic [STAT_W-1:0] stallcount
);

  // Count completed accesses and cycles spent waiting with a request pending
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      icount     <= '0;
      dcount     <= '0;
      stallcount <= '0;
    end else begin
      if (ihit) icount <= icount + 1'b1;
      if (dhit) dcount <= dcount + 1'b1;
      if (active && !ihit && !dhit) stallcount <= stallcount + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_arbiter
// Description : Single-port RAM arbiter between instruction fetch and data
//               memory access. Serialises both requesters onto one RAM port,
//               alternating on contention, and returns one-cycle hit pulses
//               with registered load data.
//               Optional statistics counters: define MEM_ARB_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              halt,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] icount,
  output logic [STAT_W-1:0] dcount,
  output logic [STAT_W-1:0] stallcount
`endif
);

  arb_state_t state;
  grant_t     last_grant;
  ramstate_t  ram_st;
  logic       dreq;
  logic       ireq;
  logic       pick_data;

  assign ram_st = ramstate_t'(ramstate);
  assign dreq   = dREN | dWEN;
  assign ireq   = iREN & ~halt;

  // On contention data goes first unless it won the previous access
  assign pick_data = dreq & (~ireq | (last_grant == INSTR));

  // Arbitration FSM; strobes, address and write data are registered at grant
  // and held until the RAM reports ACCESS or ERROR
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      last_grant <= INSTR;
      ihit       <= 1'b0;
      dhit       <= 1'b0;
      iload      <= '0;
      dload      <= '0;
      ramREN     <= 1'b0;
      ramWEN     <= 1'b0;
      ramaddr    <= '0;
      ramstore   <= '0;
    end else begin
      ihit <= 1'b0;
      dhit <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_data) begin
            state   <= DACC;
            ramaddr <= daddr;
            if (dWEN) begin
              ramWEN   <= 1'b1;
              ramstore <= dstore;
            end else begin
              ramREN <= 1'b1;
            end
          end else if (ireq) begin
            state   <= IACC;
            ramaddr <= iaddr;
            ramREN  <= 1'b1;
          end
        end
        IACC: begin
          if (ram_st == ACCESS) begin
            iload      <= ramload;
            ihit       <= 1'b1;
            last_grant <= INSTR;
            ramREN     <= 1'b0;
            state      <= IDLE;
          end else if (ram_st == ERROR) begin
            // Abandon without a hit; a held request is simply re-arbitrated
            ramREN <= 1'b0;
            state  <= IDLE;
          end
        end
        DACC: begin
          if (ram_st == ACCESS) begin
            if (!ramWEN) dload <= ramload;
            dhit       <= 1'b1;
            last_grant <= DATA;
            ramREN     <= 1'b0;
            ramWEN     <= 1'b0;
            state      <= IDLE;
          end else if (ram_st == ERROR) begin
            ramREN <= 1'b0;
            ramWEN <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          ramREN <= 1'b0;
          ramWEN <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  memory_arbiter_stats u_stats (
    .CLK        (CLK),
    .RST        (RST),
    .ihit       (ihit),
    .dhit       (dhit),
    .active     (iREN | dREN | dWEN),
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_arbiter
// Description : Directed self-checking bench for memory_arbiter with a small
//               latency-programmable RAM model. Checks counters too when
//               MEM_ARB_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        halt = 1'b0;
  logic        iREN = 1'b0;
  logic [31:0] iaddr = '0;
  logic        ihit;
  logic [31:0] iload;
  logic        dREN = 1'b0;
  logic        dWEN = 1'b0;
  logic [31:0] daddr = '0;
  logic [31:0] dstore = '0;
  logic        dhit;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] icount;
  logic [31:0] dcount;
  logic [31:0] stallcount;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // RAM model controls
  int   lat = 0;
  logic force_err = 1'b0;
  int   cnt = 0;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .halt     (halt),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .ihit     (ihit),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dhit     (dhit),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
`ifdef MEM_ARB_STATS_EN
    ,
    .icount     (icount),
    .dcount     (dcount),
    .stallcount (stallcount)
`endif
  );

  always #5 CLK = ~CLK;

  // RAM model: BUSY for lat cycles of an active strobe, then ACCESS
  always_comb begin
    if (!(ramREN | ramWEN))  ramstate = 2'd0;
    else if (force_err)      ramstate = 2'd3;
    else if (cnt >= lat)     ramstate = 2'd2;
    else                     ramstate = 2'd1;
    ramload = (ramaddr == 32'h40) ? 32'h8C22_0004 : (ramaddr ^ 32'h5A5A_5A5A);
  end

  // Busy-cycle counter of the RAM model
  always @(posedge CLK) begin
    if ((ramREN | ramWEN) && ramstate == 2'd1) cnt <= cnt + 1;
    else                                        cnt <= 0;
  end

`ifdef MEM_ARB_STATS_EN
  int exp_i = 0;
  int exp_d = 0;
  int exp_s = 0;
  // Reference counts of observed hits and stall cycles
  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      exp_i <= 0; exp_d <= 0; exp_s <= 0;
    end else begin
      if (ihit) exp_i <= exp_i + 1;
      if (dhit) exp_d <= exp_d + 1;
      if ((iREN | dREN | dWEN) && !ihit && !dhit) exp_s <= exp_s + 1;
    end
  end
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    force_err = 1'b0;
    tick(); tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #1;
    n_checks++;
    if ({ihit, dhit, ramREN, ramWEN} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000", {ihit, dhit, ramREN, ramWEN});
    end
    n_checks++;
    if (iload !== 32'h0) begin n_fail++; $display("FAIL reset_iload: got %h expected 0", iload); end
    n_checks++;
    if (dload !== 32'h0) begin n_fail++; $display("FAIL reset_dload: got %h expected 0", dload); end
    n_checks++;
    if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL reset_ramaddr: got %h expected 0", ramaddr); end
    n_checks++;
    if (ramstore !== 32'h0) begin n_fail++; $display("FAIL reset_ramstore: got %h expected 0", ramstore); end
    apply_reset();
  endtask

  task automatic test_instr_read();
    int ren_n, wen_n, hits, hcyc;
    logic addr_ok;
    logic [31:0] got;
    ren_n = 0; wen_n = 0; hits = 0; hcyc = -1; addr_ok = 1'b1; got = '0;
    lat = 2; iaddr = 32'h40; iREN = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ramREN) begin ren_n++; if (ramaddr !== 32'h40) addr_ok = 1'b0; end
      if (ramWEN) wen_n++;
      if (ihit) begin hits++; if (hcyc < 0) hcyc = c; got = iload; iREN = 1'b0; end
    end
    n_checks++;
    if (ren_n != 3) begin n_fail++; $display("FAIL iread_ren_cycles: got %0d expected 3", ren_n); end
    n_checks++;
    if (wen_n != 0) begin n_fail++; $display("FAIL iread_wen_cycles: got %0d expected 0", wen_n); end
    n_checks++;
    if (hits != 1) begin n_fail++; $display("FAIL iread_hits: got %0d expected 1", hits); end
    n_checks++;
    if (hcyc != 4) begin n_fail++; $display("FAIL iread_hit_cycle: got %0d expected 4", hcyc); end
    n_checks++;
    if (got !== 32'h8C22_0004) begin n_fail++; $display("FAIL iread_iload: got %h expected 8c220004", got); end
    n_checks++;
    if (!addr_ok) begin n_fail++; $display("FAIL iread_ramaddr: got wrong address expected 00000040"); end
    n_checks++;
    if (iload !== 32'h8C22_0004) begin n_fail++; $display("FAIL iread_iload_held: got %h expected 8c220004", iload); end
  endtask

  // Runs one contended request pair and reports hit cycles and load data
  task automatic run_pair(input logic [31:0] ia, input logic [31:0] da,
                          output int icyc, output int dcyc,
                          output logic [31:0] igot, output logic [31:0] dgot);
    icyc = -1; dcyc = -1; igot = '0; dgot = '0;
    iaddr = ia; daddr = da; iREN = 1'b1; dREN = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (dhit) begin if (dcyc < 0) dcyc = c; dgot = dload; dREN = 1'b0; end
      if (ihit) begin if (icyc < 0) icyc = c; igot = iload; iREN = 1'b0; end
    end
  endtask

  task automatic test_arbitration();
    int icyc, dcyc;
    logic [31:0] igot, dgot;
    apply_reset();
    lat = 0;
    run_pair(32'h200, 32'h300, icyc, dcyc, igot, dgot);
    n_checks++;
    if (dcyc != 2) begin n_fail++; $display("FAIL arb1_dhit_cycle: got %0d expected 2", dcyc); end
    n_checks++;
    if (icyc != 4) begin n_fail++; $display("FAIL arb1_ihit_cycle: got %0d expected 4", icyc); end
    n_checks++;
    if (dgot !== 32'h5A5A_595A) begin n_fail++; $display("FAIL arb1_dload: got %h expected 5a5a595a", dgot); end
    n_checks++;
    if (igot !== 32'h5A5A_585A) begin n_fail++; $display("FAIL arb1_iload: got %h expected 5a5a585a", igot); end
    // lone data read leaves last_grant = DATA
    daddr = 32'h304; dREN = 1'b1;
    dcyc = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (dhit) begin if (dcyc < 0) dcyc = c; dgot = dload; dREN = 1'b0; end
    end
    n_checks++;
    if (dgot !== 32'h5A5A_595E || dcyc != 2) begin
      n_fail++; $display("FAIL arb_lone_read: got %h at %0d expected 5a5a595e at 2", dgot, dcyc);
    end
    run_pair(32'h204, 32'h308, icyc, dcyc, igot, dgot);
    n_checks++;
    if (icyc != 2) begin n_fail++; $display("FAIL arb2_ihit_cycle: got %0d expected 2", icyc); end
    n_checks++;
    if (dcyc != 4) begin n_fail++; $display("FAIL arb2_dhit_cycle: got %0d expected 4", dcyc); end
    n_checks++;
    if (igot !== 32'h5A5A_585E) begin n_fail++; $display("FAIL arb2_iload: got %h expected 5a5a585e", igot); end
    n_checks++;
    if (dgot !== 32'h5A5A_5952) begin n_fail++; $display("FAIL arb2_dload: got %h expected 5a5a5952", dgot); end
  endtask

  task automatic test_write();
    int hits, hcyc;
    logic wen1, ren1;
    logic [31:0] st1, ad1;
    hits = 0; hcyc = -1; wen1 = 1'b0; ren1 = 1'b1; st1 = '0; ad1 = '0;
    lat = 0; daddr = 32'h100; dstore = 32'hDEAD_BEEF; dWEN = 1'b1; dREN = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin wen1 = ramWEN; ren1 = ramREN; st1 = ramstore; ad1 = ramaddr; end
      if (dhit) begin hits++; if (hcyc < 0) hcyc = c; dWEN = 1'b0; dREN = 1'b0; end
    end
    n_checks++;
    if (wen1 !== 1'b1) begin n_fail++; $display("FAIL wr_ramWEN: got %b expected 1", wen1); end
    n_checks++;
    if (ren1 !== 1'b0) begin n_fail++; $display("FAIL wr_ramREN: got %b expected 0", ren1); end
    n_checks++;
    if (st1 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_ramstore: got %h expected deadbeef", st1); end
    n_checks++;
    if (ad1 !== 32'h100) begin n_fail++; $display("FAIL wr_ramaddr: got %h expected 00000100", ad1); end
    n_checks++;
    if (hits != 1 || hcyc != 2) begin n_fail++; $display("FAIL wr_dhit: got %0d hits at %0d expected 1 at 2", hits, hcyc); end
    n_checks++;
    if (dload !== 32'h5A5A_5952) begin n_fail++; $display("FAIL wr_dload_kept: got %h expected 5a5a5952", dload); end
  endtask

  task automatic test_error();
    int hits, hcyc;
    logic ren1, ren2;
    hits = 0; hcyc = -1; ren1 = 1'b0; ren2 = 1'b1;
    apply_reset();
    lat = 1; force_err = 1'b1; iaddr = 32'h40; iREN = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1) ren1 = ramREN;
      if (c == 2) begin ren2 = ramREN; force_err = 1'b0; end
      if (ihit) begin hits++; if (hcyc < 0) hcyc = c; iREN = 1'b0; end
    end
    n_checks++;
    if (ren1 !== 1'b1) begin n_fail++; $display("FAIL err_first_strobe: got %b expected 1", ren1); end
    n_checks++;
    if (ren2 !== 1'b0) begin n_fail++; $display("FAIL err_strobe_dropped: got %b expected 0", ren2); end
    n_checks++;
    if (hits != 1) begin n_fail++; $display("FAIL err_hits: got %0d expected 1", hits); end
    n_checks++;
    if (hcyc != 5) begin n_fail++; $display("FAIL err_retry_hit_cycle: got %0d expected 5", hcyc); end
    n_checks++;
    if (iload !== 32'h8C22_0004) begin n_fail++; $display("FAIL err_iload: got %h expected 8c220004", iload); end
  endtask

  task automatic test_halt();
    int ih, dh, ren_n, hcyc;
    ih = 0; dh = 0; ren_n = 0; hcyc = -1;
    apply_reset();
    lat = 0; halt = 1'b1; iaddr = 32'h200; daddr = 32'h300; iREN = 1'b1; dREN = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (ramREN) ren_n++;
      if (dhit) begin dh++; dREN = 1'b0; end
      if (ihit) ih++;
    end
    n_checks++;
    if (dh != 1) begin n_fail++; $display("FAIL halt_dhits: got %0d expected 1", dh); end
    n_checks++;
    if (ih != 0) begin n_fail++; $display("FAIL halt_ihits: got %0d expected 0", ih); end
    n_checks++;
    if (ren_n != 1) begin n_fail++; $display("FAIL halt_ren_cycles: got %0d expected 1", ren_n); end
    // release halt, then raise it again while the fetch is in flight
    ih = 0;
    lat = 3; halt = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 2) halt = 1'b1;
      if (ihit) begin ih++; if (hcyc < 0) hcyc = c; iREN = 1'b0; end
    end
    halt = 1'b0;
    n_checks++;
    if (ih != 1 || hcyc != 5) begin n_fail++; $display("FAIL halt_inflight_ihit: got %0d hits at %0d expected 1 at 5", ih, hcyc); end
    n_checks++;
    if (iload !== 32'h5A5A_585A) begin n_fail++; $display("FAIL halt_iload: got %h expected 5a5a585a", iload); end
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (icount !== 32'(exp_i)) begin n_fail++; $display("FAIL stats_icount: got %0d expected %0d", icount, exp_i); end
    n_checks++;
    if (dcount !== 32'(exp_d)) begin n_fail++; $display("FAIL stats_dcount: got %0d expected %0d", dcount, exp_d); end
    n_checks++;
    if (stallcount !== 32'(exp_s)) begin n_fail++; $display("FAIL stats_stallcount: got %0d expected %0d", stallcount, exp_s); end
  endtask
`endif

  task automatic test_reset_mid();
    int dh, ren_n;
    dh = 0; ren_n = 0;
    apply_reset();
    lat = 5; daddr = 32'h300; dREN = 1'b1;
    tick(); tick();
    n_checks++;
    if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rst_mid_inflight: got %b expected 1", ramREN); end
    RST = 1'b1;
    #1;
    n_checks++;
    if ({ramREN, ramWEN, dhit, ihit} !== 4'b0000) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b expected 0000", {ramREN, ramWEN, dhit, ihit});
    end
    n_checks++;
    if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL rst_mid_ramaddr: got %h expected 0", ramaddr); end
    n_checks++;
    if (dload !== 32'h0) begin n_fail++; $display("FAIL rst_mid_dload: got %h expected 0", dload); end
`ifdef MEM_ARB_STATS_EN
    n_checks++;
    if ({icount, dcount, stallcount} !== 96'h0) begin n_fail++; $display("FAIL rst_mid_counters: got %h expected 0", {icount, dcount, stallcount}); end
`endif
    dREN = 1'b0;
    tick(); tick();
    RST = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (dhit) dh++;
      if (ramREN | ramWEN) ren_n++;
    end
    n_checks++;
    if (dh != 0) begin n_fail++; $display("FAIL rst_mid_no_dhit: got %0d expected 0", dh); end
    n_checks++;
    if (ren_n != 0) begin n_fail++; $display("FAIL rst_mid_no_strobe: got %0d expected 0", ren_n); end
  endtask

  initial begin
    test_reset();
    test_instr_read();
    test_arbitration();
    test_write();
    test_error();
    test_halt();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
